// File: rtl/hwpe_stream_tcdm_fetch.sv
// Strided TCDM read engine feeding a stream source through a credit-limited FIFO.
// Optional macro HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of request cycles that were not granted.
module hwpe_stream_tcdm_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o
`ifdef HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          stride_q, stride_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [31:0]          mem_q [FIFO_DEPTH];
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W:0]       credits;

  logic hs, resp_keep, resp_drop, push, pop, fifo_empty, start_acc;

  assign hs         = req_q & tcdm_gnt_i;
  assign resp_drop  = tcdm_r_valid_i & (drop_q != '0);
  assign resp_keep  = tcdm_r_valid_i & (drop_q == '0);
  assign fifo_empty = (cnt_q == '0);
  assign push       = resp_keep & ~clear_i;
  assign pop        = ~fifo_empty & stream_ready_i & ~clear_i;
  assign start_acc  = (state_q == IDLE) & start_i & (drop_q == '0) &
                      (len_i != '0) & ~clear_i;

  // Next-state, counters and credit-gated request decision
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    out_d    = out_q + CNT_W'(hs) - CNT_W'(resp_keep);
    drop_d   = drop_q - CNT_W'(resp_drop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wptr_d   = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + PTR_W'(1) : rptr_q;

    if (hs) begin
      addr_d   = addr_q + stride_q;
      issued_d = issued_q + LEN_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i && (drop_q == '0)) begin
          if (len_i != '0) begin
            state_d  = RUN;
            addr_d   = base_addr_i;
            stride_d = stride_i;
            len_d    = len_i;
            issued_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs && ((issued_q + LEN_WIDTH'(1)) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((out_q == '0) && fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Soft clear: abandon the transfer, remember in-flight reads to discard
    if (clear_i) begin
      state_d  = IDLE;
      issued_d = '0;
      done_d   = 1'b0;
      drop_d   = drop_d + out_d;
      out_d    = '0;
      cnt_d    = '0;
      wptr_d   = '0;
      rptr_d   = '0;
    end

    credits = {1'b0, out_d} + {1'b0, cnt_d};
    req_d   = (state_d == RUN) && (issued_d < len_d) &&
              (credits < (CNT_W+1)'(FIFO_DEPTH));
    busy_d  = (state_d != IDLE) || (drop_d != '0);
  end

  // Control and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Response buffer storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= tcdm_r_data_i;
    end
  end

`ifdef HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of request cycles left ungranted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (clear_i || start_acc) begin
      stall_q <= '0;
    end else if (req_q && !tcdm_gnt_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign tcdm_req_o     = req_q;
  assign tcdm_add_o     = addr_q;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = 4'hF;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = ~fifo_empty;
  assign stream_data_o  = mem_q[rptr_q];
  assign stream_strb_o  = 4'hF;

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetch.sv
// Directed bench for hwpe_stream_tcdm_fetch with a one-cycle-latency TCDM model.
module tb_hwpe_stream_tcdm_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] stride_i;
  logic [15:0] len_i;
  logic        busy_o, done_o;
  logic        tcdm_req_o;
  logic        tcdm_gnt_i = 1'b0;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_data_o;
  logic [31:0] tcdm_r_data_i = '0;
  logic        tcdm_r_valid_i = 1'b0;
  logic        stream_valid_o;
  logic        stream_ready_i = 1'b0;
  logic [31:0] stream_data_o;
  logic [3:0]  stream_strb_o;
`ifdef HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  hwpe_stream_tcdm_fetch #(.FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .stride_i       (stride_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .stream_data_o  (stream_data_o),
    .stream_strb_o  (stream_strb_o)
`ifdef HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Control owned by the stimulus process
  int   gnt_limit  = 32'h7FFF_FFFF;
  int   resp_limit = 32'h7FFF_FFFF;
  logic gnt_rand   = 1'b0;
  logic ready_en   = 1'b0;

  // State owned by the memory/monitor process
  logic [31:0] pend[$];
  logic [31:0] grants[$];
  logic [31:0] beats[$];
  int   gnt_used = 0, resp_used = 0, done_cnt = 0, stall_model = 0;
  int   hold_bad = 0;
  logic prev_req_wait = 1'b0, prev_str_wait = 1'b0, prev_clear = 1'b0;
  logic [31:0] prev_add = '0, prev_data = '0;

  // Snapshots taken at each start
  int g0 = 0, b0 = 0, d0 = 0, s0 = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // TCDM model (one-cycle latency), stream sink and protocol monitor
  always @(negedge clk_i) begin : mon
    logic g;
    if (!rst_ni) begin
      pend.delete();
      tcdm_gnt_i     = 1'b0;
      tcdm_r_valid_i = 1'b0;
      stream_ready_i = 1'b0;
      prev_req_wait  = 1'b0;
      prev_str_wait  = 1'b0;
      prev_clear     = 1'b0;
    end else begin
      if (prev_req_wait && !prev_clear &&
          (!tcdm_req_o || tcdm_add_o !== prev_add)) hold_bad++;
      if (prev_str_wait && !prev_clear &&
          (!stream_valid_o || stream_data_o !== prev_data)) hold_bad++;

      if (pend.size() > 0 && resp_used < resp_limit) begin
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = mem_f(pend.pop_front());
        resp_used++;
      end else begin
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
      end

      g = (gnt_used < gnt_limit) && (!gnt_rand || ($urandom_range(0, 1) == 1));
      tcdm_gnt_i = g;
      if (tcdm_req_o && g) begin
        grants.push_back(tcdm_add_o);
        pend.push_back(tcdm_add_o);
        gnt_used++;
      end
      if (tcdm_req_o && !g) stall_model++;

      stream_ready_i = ready_en;
      if (stream_valid_o && ready_en) beats.push_back(stream_data_o);
      if (done_o) done_cnt++;

      prev_req_wait = tcdm_req_o && !g;
      prev_add      = tcdm_add_o;
      prev_str_wait = stream_valid_o && !ready_en;
      prev_data     = stream_data_o;
      prev_clear    = clear_i;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
    g0 = grants.size(); b0 = beats.size(); d0 = done_cnt; s0 = stall_model;
    base_addr_i = b; stride_i = s; len_i = l; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy_o || stream_valid_o || pend.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    tick(2);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] b, input logic [31:0] s, input int n);
    logic [31:0] a, ga, gb;
    check({tag, "_ngrant"}, 32'(grants.size() - g0), 32'(n));
    check({tag, "_nbeat"}, 32'(beats.size() - b0), 32'(n));
    for (int i = 0; i < n; i++) begin
      a  = b + 32'(i) * s;
      ga = (g0 + i < grants.size()) ? grants[g0 + i] : 32'hDEAD_BEEF;
      gb = (b0 + i < beats.size()) ? beats[b0 + i] : 32'hDEAD_BEEF;
      check($sformatf("%s_addr%0d", tag, i), ga, a);
      check($sformatf("%s_data%0d", tag, i), gb, mem_f(a));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = '0; stride_i = '0; len_i = '0;
    tick(3);
    check("rst_req",   32'(tcdm_req_o),     32'd0);
    check("rst_add",   tcdm_add_o,          32'd0);
    check("rst_valid", 32'(stream_valid_o), 32'd0);
    check("rst_data",  stream_data_o,       32'd0);
    check("rst_busy",  32'(busy_o),         32'd0);
    check("rst_done",  32'(done_o),         32'd0);
    check("const_wen", 32'(tcdm_wen_o),     32'd1);
    check("const_be",  32'(tcdm_be_o),      32'hF);
    rst_ni = 1'b1;
    tick(2);

    // 1: basic stride-4 transfer, latency grant N -> valid N+2
    ready_en = 1'b1;
    start_xfer(32'h1000, 32'd4, 16'd4);
    check("t1_req",  32'(tcdm_req_o), 32'd1);
    check("t1_busy", 32'(busy_o),     32'd1);
    check("t1_add0", tcdm_add_o,      32'h1000);
    tick(1);
    check("t1_valid_n1", 32'(stream_valid_o), 32'd0);
    tick(1);
    check("t1_valid_n2", 32'(stream_valid_o), 32'd1);
    check("t1_head",     stream_data_o,       mem_f(32'h1000));
    wait_idle("t1", 60);
    check_seq("t1", 32'h1000, 32'd4, 4);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_end", 32'(busy_o), 32'd0);

    // 2: zero length
    start_xfer(32'h5000, 32'd4, 16'd0);
    check("t2_done_pulse", 32'(done_o),     32'd1);
    check("t2_req",        32'(tcdm_req_o), 32'd0);
    check("t2_busy",       32'(busy_o),     32'd0);
    tick(1);
    check("t2_done_low", 32'(done_o), 32'd0);
    tick(4);
    check("t2_ngrant", 32'(grants.size() - g0), 32'd0);
    check("t2_done",   32'(done_cnt - d0),      32'd1);

    // 3: credit limit under backpressure
    ready_en = 1'b0;
    start_xfer(32'h2000, 32'd4, 16'd8);
    tick(15);
    check("t3_ngrant4", 32'(grants.size() - g0), 32'd4);
    check("t3_req",     32'(tcdm_req_o),         32'd0);
    check("t3_valid",   32'(stream_valid_o),     32'd1);
    check("t3_head",    stream_data_o,           mem_f(32'h2000));
    ready_en = 1'b1;
    wait_idle("t3", 80);
    check_seq("t3", 32'h2000, 32'd4, 8);
    check("t3_done", 32'(done_cnt - d0), 32'd1);

    // 4: address wrap with random grant gaps
    gnt_rand = 1'b1;
    start_xfer(32'hFFFF_FFF8, 32'd8, 16'd3);
    wait_idle("t4", 300);
    gnt_rand = 1'b0;
    check_seq("t4", 32'hFFFF_FFF8, 32'd8, 3);
    check("t4_done", 32'(done_cnt - d0), 32'd1);
`ifdef HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN
    check("t4_stall", stall_cnt_o, 32'(stall_model - s0));
`endif

    // 5: clear with 2 outstanding and 1 buffered
    ready_en   = 1'b0;
    gnt_limit  = gnt_used + 3;
    resp_limit = resp_used + 1;
    start_xfer(32'h3000, 32'd4, 16'd8);
    tick(10);
    check("t5_ngrant", 32'(grants.size() - g0), 32'd3);
    check("t5_valid",  32'(stream_valid_o),     32'd1);
    check("t5_req",    32'(tcdm_req_o),         32'd1);
    clear_i = 1'b1;
    tick(1);
    clear_i  = 1'b0;
    ready_en = 1'b1;
    check("t5_valid_clr", 32'(stream_valid_o), 32'd0);
    check("t5_req_clr",   32'(tcdm_req_o),     32'd0);
    check("t5_busy_clr",  32'(busy_o),         32'd1);
    gnt_limit = 32'h7FFF_FFFF;
    base_addr_i = 32'h6000; stride_i = 32'd4; len_i = 16'd2; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(1);
    check("t5_start_ignored", 32'(tcdm_req_o), 32'd0);
    check("t5_busy_hold",     32'(busy_o),     32'd1);
    resp_limit = 32'h7FFF_FFFF;
    tick(1);
    check("t5_busy_drop1", 32'(busy_o), 32'd1);
    tick(1);
    check("t5_busy_drop2", 32'(busy_o), 32'd0);
    tick(3);
    check("t5_nbeat",  32'(beats.size() - b0), 32'd0);
    check("t5_nodone", 32'(done_cnt - d0),     32'd0);
    start_xfer(32'h4000, 32'd4, 16'd2);
    wait_idle("t5b", 60);
    check_seq("t5b", 32'h4000, 32'd4, 2);
    check("t5b_done", 32'(done_cnt - d0), 32'd1);

    // 6: async reset mid-transfer
    ready_en = 1'b0;
    start_xfer(32'h7000, 32'd4, 16'd8);
    tick(3);
    rst_ni = 1'b0;
    #1;
    check("t6_req",   32'(tcdm_req_o),     32'd0);
    check("t6_add",   tcdm_add_o,          32'd0);
    check("t6_valid", 32'(stream_valid_o), 32'd0);
    check("t6_data",  stream_data_o,       32'd0);
    check("t6_busy",  32'(busy_o),         32'd0);
    tick(2);
    rst_ni   = 1'b1;
    ready_en = 1'b1;
    tick(2);
    start_xfer(32'h8000, 32'd4, 16'd2);
    wait_idle("t6b", 60);
    check_seq("t6b", 32'h8000, 32'd4, 2);
    check("t6b_done", 32'(done_cnt - d0), 32'd1);

    check("hold_violations", 32'(hold_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_fetch.md
Name: hwpe_stream_tcdm_fetch

Overview:
Strided TCDM read engine that sits directly upstream of a stream consumer. It issues a programmed sequence of 32-bit TCDM read requests and buffers the responses in a small internal FIFO. It then emits the read data in request order on a stream source interface. It bridges a TCDM master port to the stream domain, with credit-based flow control so that sink backpressure never drops data.

Parameters:
FIFO_DEPTH, 4, response buffer entries; power of two, >= 2; also the maximum number of credits (outstanding requests plus buffered beats)
LEN_WIDTH, 16, width of the transfer length field and of the issued/remaining counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
start_i  in  1  one-cycle start pulse; config sampled on this cycle
base_addr_i  in  32  first byte address
stride_i  in  32  address increment per beat (two's-complement wrap)
len_i  in  LEN_WIDTH  number of beats
busy_o  out  1  engine not idle, or dropping stale responses
done_o  out  1  one-cycle pulse at end of a transfer
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  32  TCDM address
tcdm_wen_o  out  1  constant 1 (read)
tcdm_be_o  out  4  constant 4'hF
tcdm_data_o  out  32  constant 0
tcdm_r_data_i  in  32  read data
tcdm_r_valid_i  in  1  read data valid
stream_valid_o  out  1  stream valid
stream_ready_i  in  1  stream ready
stream_data_o  out  32  stream data (FIFO head)
stream_strb_o  out  4  constant 4'hF

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE; all counters and FIFO pointers 0; addr register 0.
  - Outputs at reset: tcdm_req_o=0, tcdm_add_o=0, stream_valid_o=0, stream_data_o=0, busy_o=0, done_o=0.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: start_i=1 and len_i!=0 and drop_cnt==0 -> latch base/stride/len, go to RUN.
  - IDLE: start_i=1 and len_i==0 -> done_o=1 on the next cycle, stay IDLE, no request.
  - IDLE: start_i is ignored whenever busy_o=1.
  - RUN: issued==len after a handshake -> DRAIN.
  - DRAIN: outstanding==0 and FIFO empty -> done_o=1 for one cycle, go to IDLE.
- Request rule:
  - tcdm_req_o=1 in RUN iff issued<len and (outstanding + fifo_count) < FIFO_DEPTH.
  - Once asserted, tcdm_req_o and tcdm_add_o hold stable until tcdm_gnt_i=1; only clear_i or reset may withdraw a request.
  - On handshake (req & gnt): addr += stride (mod 2^32), issued++, outstanding++.
- Response path:
  - Each tcdm_r_valid_i=1 pushes tcdm_r_data_i into the FIFO and decrements outstanding.
  - Any response latency of >=1 cycle is tolerated.
  - Same-cycle grant and r_valid: outstanding is unchanged.
- Stream out:
  - stream_valid_o = FIFO not empty; stream_data_o = FIFO head.
  - Pop on valid & ready.
  - Registered FIFO with no bypass: with zero-latency memory, grant at cycle N gives r_valid at N+1 and stream_valid_o at N+2.
  - Data and strb are stable while valid & ~ready.
  - Valid deasserts only after a handshake.
- Full/empty:
  - The credit rule guarantees no push when full.
  - Push and pop in the same cycle on a non-empty FIFO keeps the count unchanged.
- clear_i:
  - Next cycle: FSM=IDLE, FIFO flushed, issued=0, req=0.
  - Current outstanding is copied into drop_cnt; responses are discarded and decrement drop_cnt.
  - busy_o=1 while drop_cnt!=0.
  - No done_o pulse is generated.
- Counters never wrap: issued <= len <= 2^LEN_WIDTH-1; outstanding <= FIFO_DEPTH.

Optional Feature:
Macro: HWPE_STREAM_TCDM_FETCH_STALL_CNT_EN.
- When defined: adds output stall_cnt_o (32-bit) that counts cycles with tcdm_req_o & ~tcdm_gnt_i.
  - Saturates at 32'hFFFFFFFF.
  - Resets to 0 on rst_ni, clear_i, and accepted start_i.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. base=0x1000, stride=4, len=4, zero-latency memory, gnt=1, ready=1 -> addresses 0x1000, 0x1004, 0x1008, 0x100C; 4 beats out in order; single done_o pulse; busy_o returns to 0.
2. start with len=0 -> no tcdm_req_o ever; done_o=1 exactly one cycle after start; busy_o stays 0.
3. FIFO_DEPTH=4, len=8, ready=0 -> exactly 4 grants, then req=0. Raise ready -> remaining 4 issued; 8 beats out in address order; no overflow.
4. base=0xFFFFFFF8, stride=8, len=3, gnt randomly low -> addresses 0xFFFFFFF8, 0x00000000, 0x00000008; tcdm_add_o stable across every req & ~gnt cycle.
5. clear_i in RUN with 2 requests outstanding and 1 beat buffered -> stream_valid_o=0 next cycle; the 2 late responses are dropped; busy_o falls after the second; a subsequent start runs cleanly.
6. rst_ni low mid-transfer -> all outputs at reset values immediately (async); after release the engine is idle and accepts a new start.
